// File: rtl/rf_pkg.sv
// Shared constants for the scoreboarded register file: default sizes, depth helper and
// the encodings of the bypass / hard-wired-zero configuration parameters.
package rf_pkg;

    localparam int unsigned DefaultW  = 4;
    localparam int unsigned DefaultAw = 2;

    localparam int unsigned ModeBypassOff = 0;
    localparam int unsigned ModeBypassOn  = 1;
    localparam int unsigned ModeZeroOff   = 0;
    localparam int unsigned ModeZeroOn    = 1;

    // Number of registers addressed by an aw-bit address.
    function automatic int unsigned rf_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: issue sets a register's busy bit, write-back clears it, and a
// registered counter tracks how many bits are set.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned AW      = DefaultAw,
    parameter int unsigned ZERO_R0 = ModeZeroOff,
    localparam int unsigned Depth  = rf_depth(AW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iss,
    input  logic [AW-1:0]    ia,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    output logic [Depth-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [Depth-1:0] busy_q, busy_d;
    logic [Depth-1:0] set_vec, clr_vec;
    logic [AW:0]      cnt_q, cnt_d;
    logic             inc, dec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss && !((ZERO_R0 == ModeZeroOn) && (ia == '0))) begin
            set_vec[ia] = 1'b1;
        end
        if (we) begin
            clr_vec[wa] = 1'b1;
        end
        // Set overrides clear: a new producer supersedes the one completing.
        busy_d = (busy_q & ~clr_vec) | set_vec;
        // At most one set and one clear per cycle, so the count moves by one at most.
        inc    = |(set_vec & ~busy_q);
        dec    = |(clr_vec & busy_q & ~set_vec);
        case ({inc, dec})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/register_file_sb.sv
// Register file with one synchronous write port, two combinational read ports, optional
// write-to-read bypass, optional hard-wired-zero register 0 and a busy-bit scoreboard.
module register_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned AW      = DefaultAw,
    parameter int unsigned BYPASS  = ModeBypassOn,
    parameter int unsigned ZERO_R0 = ModeZeroOff
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    output logic          busy1,
    output logic          busy2,
    input  logic          iss,
    input  logic [AW-1:0] ia,
    output logic [AW:0]   busy_cnt,
    output logic          idle
);

    localparam int unsigned Depth = rf_depth(AW);
    localparam bit BypassEn = (BYPASS == ModeBypassOn);
    localparam bit ZeroEn   = (ZERO_R0 == ModeZeroOn);

    logic [W-1:0]     regs_q [Depth];
    logic [Depth-1:0] busy;
    logic             wr_en;

    assign wr_en = we && !(ZeroEn && (wa == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    rf_scoreboard #(
        .AW      (AW),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss      (iss),
        .ia       (ia),
        .we       (we),
        .wa       (wa),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Two identical read ports; zero masking takes priority over bypass.
    logic [AW-1:0] ra    [2];
    logic [W-1:0]  rd    [2];
    logic          rbusy [2];

    assign ra[0] = ra1;
    assign ra[1] = ra2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic fwd;
        assign fwd = BypassEn && we && (wa == ra[p]);
        always_comb begin
            rd[p]    = fwd ? wd : regs_q[ra[p]];
            rbusy[p] = busy[ra[p]] && !fwd;
            if (ZeroEn && (ra[p] == '0)) begin
                rd[p]    = '0;
                rbusy[p] = 1'b0;
            end
        end
    end

    assign rd1   = rd[0];
    assign rd2   = rd[1];
    assign busy1 = rbusy[0];
    assign busy2 = rbusy[1];
    assign idle  = (busy_cnt == '0);

endmodule
